// File: rtl/ksa_shuffle.sv
// RC4 key-scheduling swap loop over a shared 256x8 s_memory.
// One read-read-write-write pass per i (6 cycles), j accumulated across iterations.
module ksa_shuffle #(
  parameter int KEY_LEN = 3,
  parameter int KEY_W   = 8 * KEY_LEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [KEY_W-1:0] secret_key,
  input  logic [7:0]       s_q,
  output logic [7:0]       address,
  output logic [7:0]       data,
  output logic             wren,
  output logic             busy,
  output logic             done
);

  localparam int KI_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam logic [KI_W-1:0] KI_LAST = KI_W'(KEY_LEN - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_I = 3'd1,
    WT_I = 3'd2,
    RD_J = 3'd3,
    WT_J = 3'd4,
    WR_I = 3'd5,
    WR_J = 3'd6,
    DONE = 3'd7
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      i_q, i_d;
  logic [7:0]      j_q, j_d;
  logic [7:0]      si_q, si_d;
  logic [7:0]      sj_q, sj_d;
  logic [KI_W-1:0] kidx_q, kidx_d;
  logic [7:0]      key_byte;

  // Key byte 0 is the most significant byte of secret_key; kidx tracks i mod KEY_LEN.
  always_comb begin
    key_byte = '0;
    for (int k = 0; k < KEY_LEN; k++) begin
      if (kidx_q == KI_W'(k)) key_byte = secret_key[8*(KEY_LEN-k)-1 -: 8];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      kidx_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      kidx_q  <= kidx_d;
    end
  end

  always_comb begin
    // NOTE: hold-value defaults first, so no path through the case infers a latch.
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    kidx_d  = kidx_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RD_I;
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
        end
      end
      RD_I: state_d = WT_I;
      WT_I: begin
        si_d    = s_q;
        j_d     = j_q + s_q + key_byte;
        state_d = RD_J;
      end
      RD_J: state_d = WT_J;
      WT_J: begin
        sj_d    = s_q;
        state_d = WR_I;
      end
      WR_I: state_d = WR_J;
      WR_J: begin
        if (i_q == 8'd255) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + 8'd1;
          kidx_d  = (kidx_q == KI_LAST) ? '0 : kidx_q + 1'b1;
          state_d = RD_I;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory-side outputs are pure decodes of the registered state, i and j.
  always_comb begin
    address = '0;
    data    = '0;
    wren    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      RD_I: begin address = i_q; busy = 1'b1; end
      WT_I: busy = 1'b1;
      RD_J: begin address = j_q; busy = 1'b1; end
      WT_J: busy = 1'b1;
      WR_I: begin address = i_q; data = sj_q; wren = 1'b1; busy = 1'b1; end
      WR_J: begin address = j_q; data = si_q; wren = 1'b1; busy = 1'b1; end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ksa_shuffle.sv
// Bench for ksa_shuffle: behavioural s_memory, vector table for early iterations,
// and a write scoreboard fed by a software RC4-KSA model for full runs.
module tb_ksa_shuffle;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [23:0] secret_key;
  logic [7:0]  s_q;
  logic [7:0]  address;
  logic [7:0]  data;
  logic        wren;
  logic        busy;
  logic        done;

  logic [7:0]  mem [256];
  logic [7:0]  model_s [256];
  logic        init_mem = 1'b0;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;
  wr_t exp_q[$];
  wr_t sb_e;

  typedef struct {
    logic [23:0] key;
    int          off;
    logic        wren;
    logic [7:0]  addr;
    logic [7:0]  data;
  } vec_t;
  vec_t vecs[$];

  int checks   = 0;
  int failures = 0;
  int wren_cnt = 0;
  bit sb_en    = 1'b0;

  always #10 clk = ~clk;

  ksa_shuffle #(.KEY_LEN(3), .KEY_W(24)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .secret_key (secret_key),
    .s_q        (s_q),
    .address    (address),
    .data       (data),
    .wren       (wren),
    .busy       (busy),
    .done       (done)
  );

  // Synchronous-read memory: data for the address sampled at an edge is valid the next cycle.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (wren) begin
      mem[address] <= data;
    end
    s_q <= mem[address];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb_en && wren) begin
      wren_cnt++;
      if (exp_q.size() == 0) begin
        check("sb_unexpected_write", {address, data}, 32'hffff_ffff);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_write", {address, data}, {sb_e.addr, sb_e.data});
      end
    end
  end

  // Reference RC4 KSA on model_s; queues the two writes of each iteration in order.
  function automatic void model_gen(input logic [23:0] key);
    logic [7:0] j, si, sj, kb;
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      kb = 8'(key >> (8 * (2 - (i % 3))));
      j  = j + model_s[i] + kb;
      si = model_s[i];
      sj = model_s[j];
      exp_q.push_back('{addr: 8'(i), data: sj});
      exp_q.push_back('{addr: j, data: si});
      model_s[i] = sj;
      model_s[j] = si;
    end
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("rst_edge1_wren", wren, 0);
    check("rst_edge1_busy", busy, 0);
    @(negedge clk);
    check("rst_wren", wren, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", address, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
  endtask

  task automatic init_s();
    @(negedge clk);
    init_mem = 1'b1;
    @(negedge clk);
    init_mem = 1'b0;
    for (int k = 0; k < 256; k++) model_s[k] = 8'(k);
  endtask

  // Returns at the negedge of offset 0 (first cycle after the accepting edge).
  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_full(input logic [23:0] key, input bit poke, input string tag);
    int n;
    int errs;
    exp_q.delete();
    model_gen(key);
    wren_cnt   = 0;
    sb_en      = 1'b1;
    secret_key = key;
    start_pulse();
    check({tag, "_busy0"}, busy, 1);
    check({tag, "_done0"}, done, 0);
    n = 0;
    while (!done && n < 3000) begin
      start = poke && (n == 50);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, n, 1536);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_wren_count"}, wren_cnt, 512);
    check({tag, "_sb_left"}, exp_q.size(), 0);
    sb_en = 1'b0;
    errs  = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== model_s[k]) errs++;
    check({tag, "_mem_mismatches"}, errs, 0);
  endtask

  initial begin
    logic [23:0] cur_key;
    int          cur_off;
    bit          active;

    reset      = 1'b1;
    start      = 1'b0;
    secret_key = '0;
    repeat (2) @(posedge clk);
    reset_dut();

    vecs = '{
      '{24'h000102, 0,  1'b0, 8'd0, 8'd0},
      '{24'h000102, 1,  1'b0, 8'd0, 8'd0},
      '{24'h000102, 4,  1'b1, 8'd0, 8'd0},
      '{24'h000102, 5,  1'b1, 8'd0, 8'd0},
      '{24'h000102, 8,  1'b0, 8'd2, 8'd0},
      '{24'h000102, 10, 1'b1, 8'd1, 8'd2},
      '{24'h000102, 11, 1'b1, 8'd2, 8'd1},
      '{24'h000102, 14, 1'b0, 8'd5, 8'd0},
      '{24'h000102, 16, 1'b1, 8'd2, 8'd5},
      '{24'h000102, 17, 1'b1, 8'd5, 8'd1},
      '{24'h000000, 4,  1'b1, 8'd0, 8'd0},
      '{24'h000000, 5,  1'b1, 8'd0, 8'd0},
      '{24'h000000, 8,  1'b0, 8'd1, 8'd0},
      '{24'h000000, 10, 1'b1, 8'd1, 8'd1},
      '{24'h000000, 11, 1'b1, 8'd1, 8'd1}
    };

    active  = 1'b0;
    cur_key = '0;
    cur_off = 0;
    foreach (vecs[v]) begin
      if (!active || vecs[v].key != cur_key || vecs[v].off < cur_off) begin
        reset_dut();
        init_s();
        secret_key = vecs[v].key;
        start_pulse();
        cur_off = 0;
        cur_key = vecs[v].key;
        active  = 1'b1;
      end
      while (cur_off < vecs[v].off) begin
        @(negedge clk);
        cur_off++;
      end
      check($sformatf("vec%0d_key%06h_off%0d", v, vecs[v].key, vecs[v].off),
            {wren, address, data}, {vecs[v].wren, vecs[v].addr, vecs[v].data});
    end

    reset_dut();
    init_s();
    run_full(24'h000249, 1'b0, "run_249");

    // Abort mid-run at iteration 100 (its WR_I cycle), then repeat the full run.
    reset_dut();
    init_s();
    secret_key = 24'h000249;
    start_pulse();
    repeat (604) @(negedge clk);
    check("iter100_wr_i", {wren, address}, {1'b1, 8'd100});
    reset_dut();
    init_s();
    run_full(24'h000249, 1'b0, "rerun_249");

    reset_dut();
    init_s();
    run_full(24'h000249, 1'b1, "poke_249");
    run_full(24'h5a3c01, 1'b0, "restart_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
